// File: rtl/qsfp_mgmt_pkg.sv
// rtl/qsfp_mgmt_pkg.sv - state encoding and sizing helpers for the QSFP management controller
package qsfp_mgmt_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ABSENT = 2'd0,
    ST_RESET  = 2'd1,
    ST_INIT   = 2'd2,
    ST_READY  = 2'd3
  } qsfp_state_e;

  // Counter width able to hold 0 .. max_val-1, never narrower than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qsfp_mgmt_ctrl_if.sv
// rtl/qsfp_mgmt_ctrl_if.sv - QSFP pin and host control bundle
interface qsfp_mgmt_ctrl_if;
  import qsfp_mgmt_pkg::*;

  logic               qsfp_modprsl;
  logic               qsfp_intl;
  logic               sw_reset_req;
  logic               lpmode_req;
  logic               irq_clr;
  logic               qsfp_resetl;
  logic               qsfp_modsell;
  logic               qsfp_lpmode;
  logic               module_ready;
  logic               irq_pending;
  logic [STATE_W-1:0] state_o;

  // Host / board side
  modport master (
    output qsfp_modprsl, qsfp_intl, sw_reset_req, lpmode_req, irq_clr,
    input  qsfp_resetl, qsfp_modsell, qsfp_lpmode, module_ready, irq_pending, state_o
  );

  // Controller side
  modport slave (
    input  qsfp_modprsl, qsfp_intl, sw_reset_req, lpmode_req, irq_clr,
    output qsfp_resetl, qsfp_modsell, qsfp_lpmode, module_ready, irq_pending, state_o
  );

endinterface

// File: rtl/qsfp_debounce.sv
// rtl/qsfp_debounce.sv - modprsl synchronizer and presence debounce
module qsfp_debounce
  import qsfp_mgmt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 125000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic present_db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          present_raw;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; resets to 1 so the module reads as absent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
    end
  end

  assign present_raw = ~sync2;

  // Flip present_db only after the raw level disagrees for DEBOUNCE_CYCLES straight cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      present_db <= 1'b0;
    end else if (present_raw == present_db) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt        <= '0;
      present_db <= present_raw;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qsfp_mgmt_ctrl.sv
// rtl/qsfp_mgmt_ctrl.sv - QSFP module presence/reset/init sequencer; QSFP_INTL_LATCH_EN enables the intl latch
module qsfp_mgmt_ctrl
  import qsfp_mgmt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int RESET_CYCLES    = 1250,
  parameter int INIT_CYCLES     = 250000000
) (
  input logic             clk,
  input logic             rst_n,
  qsfp_mgmt_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = max_int(DEBOUNCE_CYCLES, max_int(RESET_CYCLES, INIT_CYCLES));
  localparam int CW = cnt_width(MAX_CYCLES);
  localparam logic [CW-1:0] RESET_TERM = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] INIT_TERM  = CW'(INIT_CYCLES - 1);

  qsfp_state_e   state;
  qsfp_state_e   next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          present_db;
  logic          resetl_q;
  logic          modsell_q;
  logic          lpmode_q;
  logic          ready_q;

  qsfp_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (bus.qsfp_modprsl),
    .present_db(present_db)
  );

  // State and dwell counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ABSENT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next state: loss of presence overrides everything; sw reset only acts once the module is out of reset
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    if (!present_db) begin
      next_state = ST_ABSENT;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_ABSENT: begin
          next_state = ST_RESET;
          cnt_next   = '0;
        end
        ST_RESET: begin
          if (cnt == RESET_TERM) begin
            next_state = ST_INIT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ST_INIT: begin
          if (bus.sw_reset_req) begin
            next_state = ST_RESET;
            cnt_next   = '0;
          end else if (cnt == INIT_TERM) begin
            next_state = ST_READY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ST_READY: begin
          if (bus.sw_reset_req) begin
            next_state = ST_RESET;
            cnt_next   = '0;
          end
        end
        default: begin
          next_state = ST_ABSENT;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Pin outputs decoded from next_state so they change on the same edge as state_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resetl_q  <= 1'b0;
      modsell_q <= 1'b1;
      lpmode_q  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      resetl_q  <= (next_state == ST_INIT) || (next_state == ST_READY);
      modsell_q <= (next_state == ST_ABSENT);
      lpmode_q  <= (next_state == ST_READY) ? bus.lpmode_req : 1'b1;
      ready_q   <= (next_state == ST_READY);
    end
  end

  assign bus.qsfp_resetl  = resetl_q;
  assign bus.qsfp_modsell = modsell_q;
  assign bus.qsfp_lpmode  = lpmode_q;
  assign bus.module_ready = ready_q;
  assign bus.state_o      = state;

`ifdef QSFP_INTL_LATCH_EN
  logic intl_s1;
  logic intl_s2;
  logic intl_prev;
  logic intl_fall;
  logic irq_q;

  // intl synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intl_s1   <= 1'b0;
      intl_s2   <= 1'b0;
      intl_prev <= 1'b0;
    end else begin
      intl_s1   <= bus.qsfp_intl;
      intl_s2   <= intl_s1;
      intl_prev <= intl_s2;
    end
  end

  assign intl_fall = intl_prev & ~intl_s2;

  // Interrupt latch: set beats clear, and it only lives while READY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (next_state != ST_READY) begin
      irq_q <= 1'b0;
    end else if ((state == ST_READY) && intl_fall) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq_pending = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = bus.qsfp_intl ^ bus.irq_clr;
  assign bus.irq_pending   = 1'b0;
`endif

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// tb/tb_qsfp_mgmt_ctrl.sv - self-checking bench for qsfp_mgmt_ctrl
module tb_qsfp_mgmt_ctrl;
  import qsfp_mgmt_pkg::*;

  localparam int DB = 4;
  localparam int RC = 8;
  localparam int IC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  qsfp_mgmt_ctrl_if bus();

  qsfp_mgmt_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RESET_CYCLES   (RC),
    .INIT_CYCLES    (IC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: input histories, run-length debounce, time-in-state sequencing
  int         cyc;
  logic [3:0] mp_hist;
  logic [3:0] in_hist;
  logic       m_pres;
  int         m_run;
  int         m_st;
  int         m_entry;
  logic       m_lp;
  logic       m_irq;

  typedef struct {
    logic modprsl;
    logic sw;
    logic lp;
    int   n;
    int   st;
    logic resetl;
    logic modsell;
    logic lpmode;
    logic ready;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    cyc     = 0;
    mp_hist = '1;
    in_hist = '0;
    m_pres  = 1'b0;
    m_run   = 0;
    m_st    = 0;
    m_entry = 0;
    m_lp    = 1'b1;
    m_irq   = 1'b0;
  endtask

  task automatic model_step();
    logic raw;
    logic fall;
    int   nst;
    cyc++;
    raw  = ~mp_hist[1];
    fall = in_hist[2] & ~in_hist[1];
    nst  = m_st;
    if (!m_pres) nst = 0;
    else begin
      case (m_st)
        0: nst = 1;
        1: if (cyc - m_entry == RC) nst = 2;
        2: if (bus.sw_reset_req) nst = 1; else if (cyc - m_entry == IC) nst = 3;
        default: if (bus.sw_reset_req) nst = 1;
      endcase
    end
    if (nst != m_st) m_entry = cyc;
`ifdef QSFP_INTL_LATCH_EN
    if (nst != 3) m_irq = 1'b0;
    else if (m_st == 3 && fall) m_irq = 1'b1;
    else if (bus.irq_clr) m_irq = 1'b0;
`else
    m_irq = 1'b0;
`endif
    m_lp = (nst == 3) ? bus.lpmode_req : 1'b1;
    if (raw != m_pres) begin
      m_run++;
      if (m_run == DB) begin
        m_pres = raw;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    mp_hist = {mp_hist[2:0], bus.qsfp_modprsl};
    in_hist = {in_hist[2:0], bus.qsfp_intl};
    m_st    = nst;
  endtask

  task automatic compare_model();
    chk("model_state",   32'(bus.state_o), m_st);
    chk("model_resetl",  32'(bus.qsfp_resetl),  32'(m_st >= 2));
    chk("model_modsell", 32'(bus.qsfp_modsell), 32'(m_st == 0));
    chk("model_lpmode",  32'(bus.qsfp_lpmode),  32'(m_lp));
    chk("model_ready",   32'(bus.module_ready), 32'(m_st == 3));
    chk("model_irq",     32'(bus.irq_pending),  32'(m_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   32'(bus.state_o), 0);
    chk({tag, "_resetl"},  32'(bus.qsfp_resetl), 0);
    chk({tag, "_modsell"}, 32'(bus.qsfp_modsell), 1);
    chk({tag, "_lpmode"},  32'(bus.qsfp_lpmode), 1);
    chk({tag, "_ready"},   32'(bus.module_ready), 0);
    chk({tag, "_irq"},     32'(bus.irq_pending), 0);
  endtask

  initial begin
    int low_cnt;
    int init_cnt;
    int remaining;
    logic mp_val;

    bus.qsfp_modprsl = 1'b1;
    bus.qsfp_intl    = 1'b1;
    bus.sw_reset_req = 1'b0;
    bus.lpmode_req   = 1'b0;
    bus.irq_clr      = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    model_reset();

    // Power-up sequence, presence loss, glitch rejection, ignored sw reset in ABSENT
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  6, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  1, 1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  7, 1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  1, 2, 1'b1, 1'b0, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 15, 2, 1'b1, 1'b0, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  1, 3, 1'b1, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b1,  1, 3, 1'b1, 1'b0, 1'b1, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  2, 3, 1'b1, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0,  6, 3, 1'b1, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0,  1, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0,  8, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0,  1, 0, 1'b0, 1'b1, 1'b1, 1'b0});

    foreach (vt[i]) begin
      bus.qsfp_modprsl = vt[i].modprsl;
      bus.sw_reset_req = vt[i].sw;
      bus.lpmode_req   = vt[i].lp;
      repeat (vt[i].n) tick();
      chk($sformatf("vec%0d_state", i),   32'(bus.state_o), vt[i].st);
      chk($sformatf("vec%0d_resetl", i),  32'(bus.qsfp_resetl), 32'(vt[i].resetl));
      chk($sformatf("vec%0d_modsell", i), 32'(bus.qsfp_modsell), 32'(vt[i].modsell));
      chk($sformatf("vec%0d_lpmode", i),  32'(bus.qsfp_lpmode), 32'(vt[i].lpmode));
      chk($sformatf("vec%0d_ready", i),   32'(bus.module_ready), 32'(vt[i].ready));
    end
    bus.sw_reset_req = 1'b0;

    // sw reset on the 10th INIT cycle: full RESET then full INIT again
    bus.qsfp_modprsl = 1'b0;
    repeat (7) tick();
    chk("swr_in_reset", 32'(bus.state_o), 1);
    repeat (8) tick();
    chk("swr_in_init", 32'(bus.state_o), 2);
    repeat (9) tick();
    chk("swr_init_c10", 32'(bus.state_o), 2);
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    chk("swr_back_reset", 32'(bus.state_o), 1);
    low_cnt = 1;
    for (int k = 0; k < 20 && bus.qsfp_resetl == 1'b0; k++) begin
      tick();
      if (bus.qsfp_resetl == 1'b0) low_cnt++;
    end
    chk("swr_resetl_low_len", low_cnt, RC);
    init_cnt = 1;
    for (int k = 0; k < 40 && bus.state_o == 2'd2; k++) begin
      tick();
      if (bus.state_o == 2'd2) init_cnt++;
    end
    chk("swr_init_len", init_cnt, IC);
    chk("swr_ready", 32'(bus.module_ready), 1);

`ifdef QSFP_INTL_LATCH_EN
    // Falling intl coincident with irq_clr: set wins; later clear alone drops it
    bus.qsfp_intl = 1'b0;
    tick();
    tick();
    chk("irq_before_set", 32'(bus.irq_pending), 0);
    bus.irq_clr = 1'b1;
    tick();
    chk("irq_set_wins", 32'(bus.irq_pending), 1);
    bus.irq_clr = 1'b0;
    tick();
    chk("irq_held", 32'(bus.irq_pending), 1);
    bus.irq_clr = 1'b1;
    tick();
    chk("irq_cleared", 32'(bus.irq_pending), 0);
    bus.irq_clr   = 1'b0;
    bus.qsfp_intl = 1'b1;
    repeat (3) tick();
`endif

    // Async reset in INIT: outputs drop without a clock edge, sequence restarts
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    repeat (8) tick();
    chk("ar_in_init", 32'(bus.state_o), 2);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("async_hold");
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    chk("ar_restart_absent", 32'(bus.state_o), 0);
    tick();
    chk("ar_restart_reset", 32'(bus.state_o), 1);

    // Randomized traffic against the reference model
    remaining = 0;
    mp_val    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (remaining == 0) begin
        mp_val    = ($urandom_range(0, 3) == 0);
        remaining = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 80));
      end
      remaining--;
      bus.qsfp_modprsl = mp_val;
      bus.sw_reset_req = ($urandom_range(0, 39) == 0);
      bus.lpmode_req   = 1'($urandom_range(0, 1));
      bus.qsfp_intl    = ($urandom_range(0, 5) != 0);
      bus.irq_clr      = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qsfp_mgmt_ctrl.md
QSFP_MGMT_CTRL -- requirements
Module: qsfp_mgmt_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 125000: cycles modprsl must be stable before presence changes (1 ms at 125 MHz).
REQ-002 Parameter RESET_CYCLES, default 1250: cycles resetl is held low per module reset (10 us).
REQ-003 Parameter INIT_CYCLES, default 250000000: cycles from resetl release to ready (2 s).
REQ-004 clk  in  1  system clock, 125 MHz (clk_125mhz_int domain).
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 qsfp_modprsl  in  1  module present, active-low; asynchronous pin.
REQ-007 qsfp_intl  in  1  module interrupt, active-low; asynchronous pin.
REQ-008 sw_reset_req  in  1  single-cycle request to re-reset the module.
REQ-009 lpmode_req  in  1  requested low-power mode while ready.
REQ-010 irq_clr  in  1  single-cycle clear of irq_pending.
REQ-011 qsfp_resetl  out  1  module reset pin, active-low.
REQ-012 qsfp_modsell  out  1  module select pin, active-low.
REQ-013 qsfp_lpmode  out  1  module low-power pin.
REQ-014 module_ready  out  1  module initialised; enables ntps_top datapath.
REQ-015 irq_pending  out  1  latched module interrupt.
REQ-016 state_o  out  2  current FSM state for status registers.

Function
REQ-017 modprsl and intl SHALL each pass a 2-FF synchronizer (2-cycle latency) before any use.
REQ-018 present_db SHALL change only after the synchronized, inverted modprsl differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-019 FSM states SHALL be ABSENT=0, RESET=1, INIT=2, READY=3, output on state_o.
REQ-020 ABSENT: resetl=0, modsell=1, lpmode=1, ready=0; present_db=1 -> RESET with counter loaded.
REQ-021 RESET: resetl=0, modsell=0, lpmode=1; after exactly RESET_CYCLES cycles in state -> INIT.
REQ-022 INIT: resetl=1, modsell=0, lpmode=1; after exactly INIT_CYCLES cycles in state -> READY.
REQ-023 READY: resetl=1, modsell=0, lpmode=lpmode_req registered (1-cycle latency), module_ready=1.
REQ-024 present_db=0 SHALL force ABSENT on the next cycle from any state, with priority over all other events.
REQ-025 sw_reset_req in INIT or READY SHALL force RESET with counter reloaded; in ABSENT or RESET it is ignored.
REQ-026 All pin outputs and module_ready SHALL be registered; counter width is clog2 of the largest parameter, no wrap (counter saturates at terminal value).
REQ-027 Leaving READY SHALL deassert module_ready on the same cycle state_o changes.

Reset
REQ-028 rst_n low SHALL asynchronously set state ABSENT, resetl=0, modsell=1, lpmode=1, module_ready=0, irq_pending=0, present_db=0, counters 0, synchronizers 0 (modprsl sync stages reset to 1 = absent).
REQ-029 Reset mid-operation SHALL restart the full debounce/RESET/INIT sequence after release.

Configuration
REQ-030 Macro QSFP_INTL_LATCH_EN defined: in READY a falling edge of synchronized intl sets irq_pending; irq_clr clears it; simultaneous set and clear -> set wins; leaving READY clears it.
REQ-031 Macro undefined: intl synchronizer and latch absent, irq_pending tied 0, irq_clr ignored.

Structure
REQ-032 Package qsfp_mgmt_pkg SHALL hold the state encoding constants and state width.
REQ-033 One sub-module, qsfp_debounce (synchronizer plus stability counter), SHALL implement REQ-017/018 for modprsl.

Verification (DEBOUNCE_CYCLES=4, RESET_CYCLES=8, INIT_CYCLES=16)
REQ-034 Assert modprsl=0 steady -> state RESET after 2+4 cycles, resetl low 8 cycles, INIT 16 cycles, then module_ready=1.
REQ-035 modprsl glitch low for 3 cycles -> state stays ABSENT, resetl stays 0.
REQ-036 In READY, modprsl=1 for 4+ cycles -> next cycle ABSENT, module_ready=0, resetl=0, modsell=1.
REQ-037 In INIT at cycle 10, pulse sw_reset_req -> RESET, resetl low for full 8 cycles, then full 16-cycle INIT.
REQ-038 With QSFP_INTL_LATCH_EN, in READY drive intl 1->0 and pulse irq_clr on the same cycle irq would set -> irq_pending=1; later irq_clr alone -> 0.
REQ-039 Drop rst_n during INIT -> all outputs at reset values immediately (no clock edge), sequence restarts from ABSENT.
